seq_mult8x8: RTL and testbench
==============================

Name: seq_mult8x8

Overview:
- Sequential 8x8 unsigned multiplier that reuses one combinational 4x4 multiplier over four accumulate cycles.
- Contains a 2-bit cycle counter, a nibble-select mux pair, the 4x4 multiplier, a shifter (0/4/8), a 16-bit adder and a 16-bit accumulator register.
- A control FSM sequences these parts; its state is shown on a 7-segment display.
- Top-level datapath block of the multiplier lab design.

Parameters:
- None. Widths are fixed: 8-bit operands, 16-bit product.

Ports:
- clk  in  1  system clock, rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- dataa  in  8  multiplicand, unsigned; must be held stable from start until done.
- datab  in  8  multiplier, unsigned; must be held stable from start until done.
- start  in  1  level request; high clears the accumulator and counter, and the operation runs after start falls.
- done_flag  out  1  high for exactly one cycle in state CALC_DONE.
- product8by8_out  out  16  accumulator output; holds the final product until the next start.
- state_out  out  3  FSM state code.
- seg_a..seg_g  out  1 each  active-low 7-segment drive of state_out.

Behaviour:
- One clock; reset is asynchronous and active-low (aclr_n); all flops use it.
- Reset values: FSM = IDLE, counter = 0, accumulator = 0, done_flag = 0, display shows "0".
- Counter: 2-bit. Synchronous clear to 0 while start = 1; otherwise increments every cycle and wraps 3 -> 0.
- Nibble selection uses sel[1:0]:
  - sel[1] chooses dataa[7:4] when 1, dataa[3:0] when 0.
  - sel[0] chooses datab[7:4] when 1, datab[3:0] when 0.
- mult4x4: 4x4 unsigned -> 8-bit product, combinational.
- Shifter: shift code 00 -> <<0, 01 -> <<4, 10 -> <<8, 11 -> <<0. The 8-bit product is zero-extended to 16 bits.
- Adder: sum = shift_out + accumulator, 16 bits, no carry out (the true product never exceeds 0xFE01).
- Accumulator: on each clock edge, sclr_n = 0 loads 0 (priority); otherwise clk_ena = 1 loads sum; otherwise holds.
- FSM (Moore outputs; codes: IDLE=0, LSB=1, MID=2, MSB=3, CALC_DONE=4, ERR=5):
  - IDLE: if start, sclr_n = 0 and go to LSB; else stay.
  - LSB: if start, sclr_n = 0 and stay. Else (count is 0): sel = 00, shift = 00, clk_ena = 1, go to MID.
  - MID: if start, go to ERR.
    - count 1: sel = 01, shift = 01, clk_ena = 1, stay.
    - count 2: sel = 10, shift = 01, clk_ena = 1, go to MSB.
  - MSB: if start, go to ERR. Else (count 3): sel = 11, shift = 10, clk_ena = 1, go to CALC_DONE.
  - CALC_DONE: done_flag = 1, clk_ena = 0, go to IDLE unconditionally.
  - ERR: clk_ena = 0; if start, sclr_n = 0 and go to LSB; else stay. The accumulator value in ERR is undefined to users.
  - Any count/state mismatch (unreachable) goes to ERR.
- Latency: start high for 1 edge, then low. Four accumulate edges follow; done_flag is high the cycle after the 4th edge.
- The product is valid from the done_flag cycle onward and holds until the next start.
- Reset mid-operation: asynchronous return to IDLE with the accumulator at 0.
- Display (active-low, listed as abcdefg, 0 = lit):
  - state 0 -> "0" = 0000001
  - state 1 -> "1" = 1001111
  - state 2 -> "2" = 0010010
  - state 3 -> "3" = 0000110
  - states 4..7 -> "E" = 0110000

Decomposition:
- Package seq_mult_pkg: state enum (IDLE..ERR with the codes above), shift codes SH0/SH4/SH8, segment constants.
- One natural sub-module: seq_mult_ctrl, containing the FSM and the counter.
- The datapath (mux, mult4x4, shifter, adder, accumulator) and the display decoder stay in the top level.

Test Plan:
- dataa = 10, datab = 20, start high for 1 edge then low: accumulator reads 0, 40, 200, 200, 200 after each edge; done_flag pulses once; product8by8_out = 0x00C8.
- dataa = 255, datab = 255: product = 0xFE01. Also dataa = 0, datab = 0xAB: product = 0.
- Start held high 3 cycles: FSM stays in LSB with count 0 and accumulator 0; result is still correct after start falls.
- Start pulsed while in MID: state_out = 5, display "E". The next start recovers via LSB and yields a correct product.
- aclr_n low during MSB: immediate IDLE, product 0, done_flag 0. The next run is correct.
- Back-to-back runs (start in the IDLE cycle after done): second result correct. Sweep 1000 random operand pairs and compare against dataa*datab.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
//   Shared definitions for the sequential 8x8 multiplier:
//   - state_t      : control FSM state encoding (also the state_out code)
//   - SH0/SH4/SH8  : shifter control codes
//   - SEG_*        : active-low 7-segment patterns, bit order {a,b,c,d,e,f,g}
//   - shift_product: zero-extend a 4x4 partial product and place it
//   - seg_decode   : state code to 7-segment pattern
package seq_mult_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LSB       = 3'd1,
        MID       = 3'd2,
        MSB       = 3'd3,
        CALC_DONE = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam logic [1:0] SH0 = 2'b00;
    localparam logic [1:0] SH4 = 2'b01;
    localparam logic [1:0] SH8 = 2'b10;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_E = 7'b0110000;

    // Code 2'b11 is not used by the FSM and falls through to no shift.
    function automatic logic [15:0] shift_product(input logic [7:0] p,
                                                  input logic [1:0] code);
        logic [15:0] ext;
        logic [15:0] res;
        ext = {8'd0, p};
        case (code)
            SH4:     res = ext << 4;
            SH8:     res = ext << 8;
            default: res = ext;
        endcase
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [2:0] code);
        logic [6:0] seg;
        case (code)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            default: seg = SEG_E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seq_mult8x8_if.sv
// seq_mult8x8_if
//   Operand / result bundle of the sequential multiplier.
//   dataa, datab    : 8-bit unsigned operands, held stable start..done
//   start           : level request, operation runs after it falls
//   done_flag       : one-cycle completion pulse
//   product8by8_out : 16-bit accumulator / product
//   master = requester side, slave = multiplier side.
interface seq_mult8x8_if;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic        start;
    logic        done_flag;
    logic [15:0] product8by8_out;

    modport master (
        output dataa,
        output datab,
        output start,
        input  done_flag,
        input  product8by8_out
    );

    modport slave (
        input  dataa,
        input  datab,
        input  start,
        output done_flag,
        output product8by8_out
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
//   Control FSM plus 2-bit cycle counter that sequence the four
//   nibble partial products through the shared 4x4 multiplier.
//   Ports:
//     clk, aclr_n : clock, asynchronous active-low reset
//     start       : level request from the user
//     state       : current FSM state (Moore)
//     sel         : nibble select {a_hi, b_hi}
//     shift       : shifter code (SH0/SH4/SH8)
//     clk_ena     : accumulator load enable
//     sclr_n      : accumulator synchronous clear, active-low
//     done_flag   : high during CALC_DONE
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic       clk,
    input  logic       aclr_n,
    input  logic       start,
    output state_t     state,
    output logic [1:0] sel,
    output logic [1:0] shift,
    output logic       clk_ena,
    output logic       sclr_n,
    output logic       done_flag
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] count;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter free-runs once start falls; it lines up with the FSM so that
    // LSB sees 0, MID sees 1 and 2, MSB sees 3.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            count <= 2'd0;
        end else if (start) begin
            count <= 2'd0;
        end else begin
            count <= count + 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel       = 2'b00;
        shift     = SH0;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        done_flag = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sclr_n  = 1'b0;
                    state_d = LSB;
                end
            end
            LSB: begin
                if (start) begin
                    sclr_n = 1'b0;
                end else if (count == 2'd0) begin
                    sel     = 2'b00;
                    shift   = SH0;
                    clk_ena = 1'b1;
                    state_d = MID;
                end else begin
                    state_d = ERR;
                end
            end
            MID: begin
                if (start) begin
                    state_d = ERR;
                end else if (count == 2'd1) begin
                    sel     = 2'b01;
                    shift   = SH4;
                    clk_ena = 1'b1;
                end else if (count == 2'd2) begin
                    sel     = 2'b10;
                    shift   = SH4;
                    clk_ena = 1'b1;
                    state_d = MSB;
                end else begin
                    state_d = ERR;
                end
            end
            MSB: begin
                if (start) begin
                    state_d = ERR;
                end else if (count == 2'd3) begin
                    sel     = 2'b11;
                    shift   = SH8;
                    clk_ena = 1'b1;
                    state_d = CALC_DONE;
                end else begin
                    state_d = ERR;
                end
            end
            CALC_DONE: begin
                done_flag = 1'b1;
                state_d   = IDLE;
            end
            ERR: begin
                if (start) begin
                    sclr_n  = 1'b0;
                    state_d = LSB;
                end
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/seq_mult8x8.sv
// seq_mult8x8
//   Sequential 8x8 unsigned multiplier: one 4x4 multiplier reused over
//   four accumulate cycles, with the FSM state shown on a 7-segment digit.
//   Ports:
//     clk, aclr_n   : clock, asynchronous active-low reset
//     bus (slave)   : dataa, datab, start in; done_flag, product8by8_out out
//     state_out     : FSM state code
//     seg_a..seg_g  : active-low segment drive of state_out
module seq_mult8x8
    import seq_mult_pkg::*;
(
    input  logic                clk,
    input  logic                aclr_n,
    seq_mult8x8_if.slave        bus,
    output logic [2:0]          state_out,
    output logic                seg_a,
    output logic                seg_b,
    output logic                seg_c,
    output logic                seg_d,
    output logic                seg_e,
    output logic                seg_f,
    output logic                seg_g
);

    state_t      state;
    logic [1:0]  sel;
    logic [1:0]  shift;
    logic        clk_ena;
    logic        sclr_n;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  mult_out;
    logic [15:0] shift_out;
    logic [15:0] sum;
    logic [15:0] acc;
    logic [6:0]  seg;

    seq_mult_ctrl u_ctrl (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .start     (bus.start),
        .state     (state),
        .sel       (sel),
        .shift     (shift),
        .clk_ena   (clk_ena),
        .sclr_n    (sclr_n),
        .done_flag (bus.done_flag)
    );

    assign nib_a     = sel[1] ? bus.dataa[7:4] : bus.dataa[3:0];
    assign nib_b     = sel[0] ? bus.datab[7:4] : bus.datab[3:0];
    assign mult_out  = {4'd0, nib_a} * {4'd0, nib_b};
    assign shift_out = shift_product(mult_out, shift);
    // The full product never exceeds 0xFE01, so the carry out is dropped.
    assign sum       = shift_out + acc;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            acc <= 16'd0;
        end else if (!sclr_n) begin
            acc <= 16'd0;
        end else if (clk_ena) begin
            acc <= sum;
        end
    end

    assign bus.product8by8_out = acc;
    assign state_out           = state;
    assign seg                 = seg_decode(state_out);
    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;

endmodule

// File: tb/tb_seq_mult8x8.sv
// tb_seq_mult8x8
//   Directed and table-driven bench for seq_mult8x8.
module tb_seq_mult8x8;
    import seq_mult_pkg::*;

    logic       clk;
    logic       aclr_n;
    logic [2:0] state_out;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [6:0] segs;

    int n_total;
    int n_pass;

    seq_mult8x8_if bus ();

    seq_mult8x8 dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .bus       (bus),
        .state_out (state_out),
        .seg_a     (seg_a),
        .seg_b     (seg_b),
        .seg_c     (seg_c),
        .seg_d     (seg_d),
        .seg_e     (seg_e),
        .seg_f     (seg_f),
        .seg_g     (seg_g)
    );

    assign segs = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, wait for done, check latency / product / single pulse.
    // Leaves the bench in the IDLE cycle following done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string name);
        int lat;
        bit seen;
        bus.dataa = a;
        bus.datab = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            lat++;
            if (bus.done_flag) seen = 1'b1;
        end
        check({name, "_latency"}, seen ? lat : 99, 4);
        check({name, "_product"}, bus.product8by8_out, exp);
        step();
        check({name, "_held"}, {bus.done_flag, state_out, bus.product8by8_out},
              {1'b0, 3'd0, exp});
    endtask

    initial begin
        logic [15:0] exp_seq[4];
        int          dones;
        logic [7:0]  ra;
        logic [7:0]  rb;

        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{8'd10,  8'd20,  16'd200};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'hAB,  16'd0};
        vecs[3] = '{8'd1,   8'd1,   16'd1};
        vecs[4] = '{8'h0F,  8'hF0,  16'h0E10};
        vecs[5] = '{8'h80,  8'h80,  16'h4000};
        vecs[6] = '{8'h12,  8'h34,  16'h03A8};
        vecs[7] = '{8'd200, 8'd3,   16'd600};

        exp_seq[0] = 16'd40;
        exp_seq[1] = 16'd200;
        exp_seq[2] = 16'd200;
        exp_seq[3] = 16'd200;

        // Reset state
        aclr_n    = 1'b0;
        bus.dataa = 8'd0;
        bus.datab = 8'd0;
        bus.start = 1'b0;
        step();
        step();
        check("rst_state", state_out, 3'd0);
        check("rst_product", bus.product8by8_out, 16'd0);
        check("rst_done", bus.done_flag, 1'b0);
        check("rst_seg", segs, SEG_0);
        aclr_n = 1'b1;
        step();
        check("idle_state", state_out, 3'd0);

        // Cycle-exact trace for 10 x 20
        bus.dataa = 8'd10;
        bus.datab = 8'd20;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("trace_acc0", bus.product8by8_out, 16'd0);
        check("trace_lsb_state", state_out, 3'd1);
        check("trace_lsb_seg", segs, SEG_1);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("trace_acc%0d", i + 1), bus.product8by8_out, exp_seq[i]);
            if (bus.done_flag) dones++;
            if (i == 0) check("trace_mid_seg", segs, SEG_2);
            if (i == 2) check("trace_msb_seg", segs, SEG_3);
        end
        check("trace_done_at_4", bus.done_flag, 1'b1);
        check("trace_done_state", state_out, 3'd4);
        step();
        if (bus.done_flag) dones++;
        check("trace_done_pulses", dones, 1);
        check("trace_hold", bus.product8by8_out, 16'd200);

        // Table-driven vectors, run back to back
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Start held high for three cycles
        bus.dataa = 8'd37;
        bus.datab = 8'd91;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_state%0d", i), state_out, 3'd1);
            check($sformatf("hold_acc%0d", i), bus.product8by8_out, 16'd0);
        end
        bus.start = 1'b0;
        begin
            int lat;
            bit seen;
            lat  = 0;
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                step();
                lat++;
                if (bus.done_flag) seen = 1'b1;
            end
            check("hold_latency", seen ? lat : 99, 4);
            check("hold_product", bus.product8by8_out, 16'd3367);
        end
        step();

        // Start pulsed while in MID
        bus.dataa = 8'd50;
        bus.datab = 8'd60;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("err_pre_state", state_out, 3'd2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("err_state", state_out, 3'd5);
        check("err_seg", segs, SEG_E);
        step();
        step();
        check("err_stays", state_out, 3'd5);
        run_op(8'd50, 8'd60, 16'd3000, "err_recover");

        // Asynchronous reset during MSB
        bus.dataa = 8'd99;
        bus.datab = 8'd77;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        check("arst_pre_state", state_out, 3'd3);
        aclr_n = 1'b0;
        #1;
        check("arst_state", state_out, 3'd0);
        check("arst_product", bus.product8by8_out, 16'd0);
        check("arst_done", bus.done_flag, 1'b0);
        check("arst_seg", segs, SEG_0);
        step();
        aclr_n = 1'b1;
        step();
        check("arst_idle", state_out, 3'd0);
        run_op(8'd99, 8'd77, 16'd7623, "arst_next");

        // Random sweep, back to back
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, 16'(ra) * 16'(rb), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
